pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit (CU) for the 5-stage core. Consumes the EXU branch/jump result, ID-stage
//  register use and the ID/EX load flag. Drives PC redirect/hold, IF/ID and ID/EX flush/hold,
//  load-use stalls and a debug halt. Sits beside the pipe registers; no datapath of its own.
// PARAMETERS
//  FLUSH_CYCLES  2  cycles IF/ID is flushed after a taken jump (1 = jump cycle only); range 1..7
//  LOAD_STALL    1  bubbles inserted per load-use hazard; range 1..7
// PORTS
//  clk                 in   1   core clock; all state changes on rising edge
//  rst_n               in   1   asynchronous, active-low reset
//  ex2cu_jump_en_i     in   1   EXU: taken branch/jump this cycle
//  ex2cu_jump_addr_i   in   32  EXU: redirect target
//  id2cu_rs1_addr_i    in   5   ID: rs1 index
//  id2cu_rs2_addr_i    in   5   ID: rs2 index
//  id2cu_rs_use_i      in   2   ID: [0] rs1 read, [1] rs2 read
//  idex2cu_rd_addr_i   in   5   ID/EX: rd of instruction in EX
//  idex2cu_load_i      in   1   ID/EX: instruction in EX is a load
//  dbg2cu_halt_req_i   in   1   debug halt request (level)
//  cu2pc_jump_en_o     out  1   PC: load jump address
//  cu2pc_jump_addr_o   out  32  PC: target; 0 when jump_en_o = 0
//  cu2pc_hold_o        out  1   PC: keep current value
//  cu2ifid_flush_o     out  1   IF/ID: load NOP
//  cu2ifid_hold_o      out  1   IF/ID: keep contents
//  cu2idex_flush_o     out  1   ID/EX: load bubble
//  cu2dbg_halted_o     out  1   registered; 1 while in HALT
// BEHAVIOUR
//  States RUN, FLUSH, STALL, HALT; 3-bit down-counter cnt. Reset: state RUN, cnt 0, halted_o 0;
//   all outputs 0 while rst_n low (comb outputs decode to RUN with idle inputs).
//  Hazard haz = load_i & rd!=0 & ((use[0]&rs1==rd) | (use[1]&rs2==rd)).
//  RUN, priority jump > haz > halt_req:
//   jump: same cycle (combinational, 0 latency) jump_en_o=1, addr_o=jump_addr_i, ifid_flush_o=1,
//    idex_flush_o=1. If FLUSH_CYCLES>1 -> FLUSH, cnt=FLUSH_CYCLES-2; else stay RUN.
//   haz (no jump): pc_hold_o=1, ifid_hold_o=1, idex_flush_o=1 this cycle. If LOAD_STALL>1 -> STALL,
//    cnt=LOAD_STALL-2; else stay RUN (hazard clears as load leaves EX).
//   halt_req (no jump, no haz): outputs idle this cycle; -> HALT next edge.
//  FLUSH: ifid_flush_o=1; jump_en_i ignored (EX holds a bubble). cnt==0 -> RUN else cnt-1.
//  STALL: pc_hold_o=1, ifid_hold_o=1, idex_flush_o=1; jump_en_i ignored. cnt==0 -> RUN else cnt-1.
//  HALT: pc_hold_o=1, ifid_hold_o=1, idex_flush_o=1, halted_o=1 (set on entry edge, cleared on
//   exit edge). halt_req_i low -> RUN next edge. halt_req_i during FLUSH/STALL deferred to RUN.
//  Flush dominates hold where both asserted on one register (pipe regs implement flush>hold).
//  rst_n low mid-FLUSH/STALL/HALT: immediate return to RUN, cnt 0, halted_o 0; no pending redirect kept.
//  cnt wraps never: loaded only on entry, decremented only in FLUSH/STALL.
// STRUCTURE
//  Shared defines (riscv_define.v/global.v): state codes CU_ST_RUN/FLUSH/STALL/HALT (2-bit),
//   ENABLE/DISABLE, REGS_ADDR, WORD_ADDR, DEFAULT_32_ZERO.
//  Sub-module: hazard_detect (combinational load-use compare -> haz). FSM + output decode in top.
// TESTING
//  1 Jump in RUN, addr 0x0000_0040, FLUSH_CYCLES=2 -> same cycle jump_en_o=1, addr_o=0x40, both flush=1;
//    next cycle ifid_flush_o=1 only; cycle after: all 0, state RUN.
//  2 load_i=1, rd=5, rs1=5, use=01, LOAD_STALL=1 -> one cycle pc_hold=ifid_hold=idex_flush=1; rd=0 -> none.
//  3 Jump and hazard same cycle -> jump outputs only, pc_hold_o=0; second jump_en_i pulse in FLUSH ignored.
//  4 halt_req_i held 5 cycles from RUN -> halted_o=1 from next edge, hold/flush set; drop req ->
//    halted_o=0 next edge, PC resumes; halt_req during STALL -> HALT entered only after return to RUN.
//  5 rst_n low asynchronously mid-FLUSH and mid-HALT -> outputs 0 without clock edge; release -> RUN idle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// State encoding, datapath widths and counter-load helper.
package pipe_ctrl_pkg;

    localparam int unsigned RegsAddrW = 5;
    localparam int unsigned WordAddrW = 32;

    localparam logic [WordAddrW-1:0] Default32Zero = '0;

    typedef enum logic [1:0] {
        CuStRun   = 2'd0,
        CuStFlush = 2'd1,
        CuStStall = 2'd2,
        CuStHalt  = 2'd3
    } cu_state_e;

    // Counter preload for a multi-cycle state; the entry cycle itself counts as one.
    function automatic logic [2:0] cnt_load(input int unsigned cycles);
        if (cycles > 1) begin
            return 3'(cycles - 2);
        end
        return 3'd0;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: flags when the instruction in ID reads the register
// a load currently in EX is about to write.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 load_i,
    input  logic [RegsAddrW-1:0] rd_addr_i,
    input  logic [RegsAddrW-1:0] rs1_addr_i,
    input  logic [RegsAddrW-1:0] rs2_addr_i,
    input  logic [1:0]           rs_use_i,
    output logic                 haz_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = rs_use_i[0] && (rs1_addr_i == rd_addr_i);
        rs2_hit = rs_use_i[1] && (rs2_addr_i == rd_addr_i);
        // x0 is never a real destination, so it cannot create a dependency.
        haz_o   = load_i && (rd_addr_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: PC redirect/hold, IF/ID and ID/EX flush/hold,
// load-use stalls and debug halt for the 5-stage core.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned LOAD_STALL   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex2cu_jump_en_i,
    input  logic [WordAddrW-1:0] ex2cu_jump_addr_i,
    input  logic [RegsAddrW-1:0] id2cu_rs1_addr_i,
    input  logic [RegsAddrW-1:0] id2cu_rs2_addr_i,
    input  logic [1:0]           id2cu_rs_use_i,
    input  logic [RegsAddrW-1:0] idex2cu_rd_addr_i,
    input  logic                 idex2cu_load_i,
    input  logic                 dbg2cu_halt_req_i,
    output logic                 cu2pc_jump_en_o,
    output logic [WordAddrW-1:0] cu2pc_jump_addr_o,
    output logic                 cu2pc_hold_o,
    output logic                 cu2ifid_flush_o,
    output logic                 cu2ifid_hold_o,
    output logic                 cu2idex_flush_o,
    output logic                 cu2dbg_halted_o
);

    localparam logic [2:0] FlushCnt = cnt_load(FLUSH_CYCLES);
    localparam logic [2:0] StallCnt = cnt_load(LOAD_STALL);
    localparam bit         FlushMulti = FLUSH_CYCLES > 1;
    localparam bit         StallMulti = LOAD_STALL > 1;

    cu_state_e  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       halted_q;
    logic       haz;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .load_i     (idex2cu_load_i),
        .rd_addr_i  (idex2cu_rd_addr_i),
        .rs1_addr_i (id2cu_rs1_addr_i),
        .rs2_addr_i (id2cu_rs2_addr_i),
        .rs_use_i   (id2cu_rs_use_i),
        .haz_o      (haz)
    );

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        cu2pc_jump_en_o   = 1'b0;
        cu2pc_jump_addr_o = Default32Zero;
        cu2pc_hold_o      = 1'b0;
        cu2ifid_flush_o   = 1'b0;
        cu2ifid_hold_o    = 1'b0;
        cu2idex_flush_o   = 1'b0;

        unique case (state_q)
            CuStRun: begin
                if (ex2cu_jump_en_i) begin
                    cu2pc_jump_en_o   = 1'b1;
                    cu2pc_jump_addr_o = ex2cu_jump_addr_i;
                    cu2ifid_flush_o   = 1'b1;
                    cu2idex_flush_o   = 1'b1;
                    if (FlushMulti) begin
                        state_d = CuStFlush;
                        cnt_d   = FlushCnt;
                    end
                end else if (haz) begin
                    cu2pc_hold_o    = 1'b1;
                    cu2ifid_hold_o  = 1'b1;
                    cu2idex_flush_o = 1'b1;
                    if (StallMulti) begin
                        state_d = CuStStall;
                        cnt_d   = StallCnt;
                    end
                end else if (dbg2cu_halt_req_i) begin
                    state_d = CuStHalt;
                end
            end
            CuStFlush: begin
                // EX holds a bubble here, so any jump_en_i is stale and ignored.
                cu2ifid_flush_o = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = CuStRun;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CuStStall: begin
                cu2pc_hold_o    = 1'b1;
                cu2ifid_hold_o  = 1'b1;
                cu2idex_flush_o = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = CuStRun;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CuStHalt: begin
                cu2pc_hold_o    = 1'b1;
                cu2ifid_hold_o  = 1'b1;
                cu2idex_flush_o = 1'b1;
                if (!dbg2cu_halt_req_i) begin
                    state_d = CuStRun;
                end
            end
            default: begin
                state_d = CuStRun;
                cnt_d   = 3'd0;
            end
        endcase

        // Keep the pipe quiet while reset is held, whatever the inputs do.
        if (!rst_n) begin
            cu2pc_jump_en_o   = 1'b0;
            cu2pc_jump_addr_o = Default32Zero;
            cu2pc_hold_o      = 1'b0;
            cu2ifid_flush_o   = 1'b0;
            cu2ifid_hold_o    = 1'b0;
            cu2idex_flush_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CuStRun;
            cnt_q    <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == CuStHalt);
        end
    end

    assign cu2dbg_halted_o = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: jump/flush, load-use stall, halt and async reset.
// A second instance with a longer load stall covers halt requests raised mid-stall.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  rs_use;
    logic [4:0]  rd;
    logic        load;
    logic        halt_req;

    logic        a_jump_en, a_hold, a_ifid_flush, a_ifid_hold, a_idex_flush, a_halted;
    logic [31:0] a_addr;
    logic        s_jump_en, s_hold, s_ifid_flush, s_ifid_hold, s_idex_flush, s_halted;
    logic [31:0] s_addr;

    // Output vector order: {jump_en, pc_hold, ifid_flush, ifid_hold, idex_flush, halted}
    logic [5:0] outs_a;
    logic [5:0] outs_s;
    assign outs_a = {a_jump_en, a_hold, a_ifid_flush, a_ifid_hold, a_idex_flush, a_halted};
    assign outs_s = {s_jump_en, s_hold, s_ifid_flush, s_ifid_hold, s_idex_flush, s_halted};

    localparam logic [5:0] OutIdle  = 6'b000000;
    localparam logic [5:0] OutJump  = 6'b101010;
    localparam logic [5:0] OutFlush = 6'b001000;
    localparam logic [5:0] OutStall = 6'b010110;
    localparam logic [5:0] OutHalt  = 6'b010111;

    int n_checks;
    int n_fail;

    pipe_ctrl #(
        .FLUSH_CYCLES (2),
        .LOAD_STALL   (1)
    ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex2cu_jump_en_i   (jump_en),
        .ex2cu_jump_addr_i (jump_addr),
        .id2cu_rs1_addr_i  (rs1),
        .id2cu_rs2_addr_i  (rs2),
        .id2cu_rs_use_i    (rs_use),
        .idex2cu_rd_addr_i (rd),
        .idex2cu_load_i    (load),
        .dbg2cu_halt_req_i (halt_req),
        .cu2pc_jump_en_o   (a_jump_en),
        .cu2pc_jump_addr_o (a_addr),
        .cu2pc_hold_o      (a_hold),
        .cu2ifid_flush_o   (a_ifid_flush),
        .cu2ifid_hold_o    (a_ifid_hold),
        .cu2idex_flush_o   (a_idex_flush),
        .cu2dbg_halted_o   (a_halted)
    );

    pipe_ctrl #(
        .FLUSH_CYCLES (2),
        .LOAD_STALL   (3)
    ) u_dut_stall (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex2cu_jump_en_i   (jump_en),
        .ex2cu_jump_addr_i (jump_addr),
        .id2cu_rs1_addr_i  (rs1),
        .id2cu_rs2_addr_i  (rs2),
        .id2cu_rs_use_i    (rs_use),
        .idex2cu_rd_addr_i (rd),
        .idex2cu_load_i    (load),
        .dbg2cu_halt_req_i (halt_req),
        .cu2pc_jump_en_o   (s_jump_en),
        .cu2pc_jump_addr_o (s_addr),
        .cu2pc_hold_o      (s_hold),
        .cu2ifid_flush_o   (s_ifid_flush),
        .cu2ifid_hold_o    (s_ifid_hold),
        .cu2idex_flush_o   (s_idex_flush),
        .cu2dbg_halted_o   (s_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        jump_en   = 1'b0;
        jump_addr = 32'h0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        rs_use    = 2'b00;
        rd        = 5'd0;
        load      = 1'b0;
        halt_req  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        set_idle();
        rst_n = 1'b0;
        #1;
        check_eq("reset_outs", 32'(outs_a), 32'(OutIdle));
        check_eq("reset_addr", a_addr, 32'h0);
        #11 rst_n = 1'b1;
        next_cycle();

        // 1: jump with FLUSH_CYCLES=2
        jump_en = 1'b1; jump_addr = 32'h0000_0040; #1;
        check_eq("jump_outs", 32'(outs_a), 32'(OutJump));
        check_eq("jump_addr", a_addr, 32'h40);
        next_cycle();
        jump_en = 1'b0; jump_addr = 32'h1234; #1;
        check_eq("flush_outs", 32'(outs_a), 32'(OutFlush));
        check_eq("flush_addr_zero", a_addr, 32'h0);
        next_cycle();
        check_eq("after_flush", 32'(outs_a), 32'(OutIdle));

        // 2: load-use hazard, LOAD_STALL=1
        set_idle();
        load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs_use = 2'b01; #1;
        check_eq("haz_rs1", 32'(outs_a), 32'(OutStall));
        next_cycle();
        load = 1'b0; #1;
        check_eq("haz_cleared", 32'(outs_a), 32'(OutIdle));
        load = 1'b1; rd = 5'd0; rs1 = 5'd0; #1;
        check_eq("haz_rd_zero", 32'(outs_a), 32'(OutIdle));
        rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; rs_use = 2'b10; #1;
        check_eq("haz_rs2", 32'(outs_a), 32'(OutStall));
        rs_use = 2'b01; #1;
        check_eq("haz_rs2_unused", 32'(outs_a), 32'(OutIdle));

        // 3: jump beats hazard; jump pulse during FLUSH ignored
        do_reset();
        jump_en = 1'b1; jump_addr = 32'h80;
        load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs_use = 2'b01; #1;
        check_eq("jump_haz_outs", 32'(outs_a), 32'(OutJump));
        check_eq("jump_haz_addr", a_addr, 32'h80);
        next_cycle();
        jump_addr = 32'h99; load = 1'b0; #1;
        check_eq("flush_jump_ign", 32'(outs_a), 32'(OutFlush));
        check_eq("flush_jump_addr", a_addr, 32'h0);
        next_cycle();
        set_idle(); #1;
        check_eq("after_flush2", 32'(outs_a), 32'(OutIdle));

        // 4: halt held 5 cycles
        do_reset();
        halt_req = 1'b1; #1;
        check_eq("halt_req_run", 32'(outs_a), 32'(OutIdle));
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check_eq($sformatf("halt_c%0d", i), 32'(outs_a), 32'(OutHalt));
        end
        next_cycle();
        halt_req = 1'b0; #1;
        check_eq("halt_drop_cycle", 32'(outs_a), 32'(OutHalt));
        next_cycle();
        check_eq("halt_exit", 32'(outs_a), 32'(OutIdle));

        // 4b: halt request raised during a 3-bubble stall
        do_reset();
        load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs_use = 2'b01; halt_req = 1'b1; #1;
        check_eq("s_haz_first", 32'(outs_s), 32'(OutStall));
        next_cycle();
        load = 1'b0; #1;
        check_eq("s_stall1", 32'(outs_s), 32'(OutStall));
        next_cycle();
        check_eq("s_stall2", 32'(outs_s), 32'(OutStall));
        next_cycle();
        check_eq("s_run_before_halt", 32'(outs_s), 32'(OutIdle));
        next_cycle();
        check_eq("s_halt", 32'(outs_s), 32'(OutHalt));
        halt_req = 1'b0;
        next_cycle();
        check_eq("s_halt_exit", 32'(outs_s), 32'(OutIdle));

        // 5: asynchronous reset mid-FLUSH and mid-HALT
        do_reset();
        jump_en = 1'b1; jump_addr = 32'h40;
        next_cycle();
        jump_en = 1'b0; #1;
        check_eq("pre_rst_flush", 32'(outs_a), 32'(OutFlush));
        #1 rst_n = 1'b0; #1;
        check_eq("rst_mid_flush", 32'(outs_a), 32'(OutIdle));
        jump_en = 1'b1; jump_addr = 32'h55; #1;
        check_eq("rst_gates_jump", 32'(outs_a), 32'(OutIdle));
        check_eq("rst_gates_addr", a_addr, 32'h0);
        jump_en = 1'b0; #1 rst_n = 1'b1;
        next_cycle();
        check_eq("rel_flush_idle", 32'(outs_a), 32'(OutIdle));
        halt_req = 1'b1;
        next_cycle();
        check_eq("pre_rst_halt", 32'(outs_a), 32'(OutHalt));
        halt_req = 1'b0; #1 rst_n = 1'b0; #1;
        check_eq("rst_mid_halt", 32'(outs_a), 32'(OutIdle));
        #1 rst_n = 1'b1;
        next_cycle();
        check_eq("rel_halt_idle", 32'(outs_a), 32'(OutIdle));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
